fetch_queue: RTL

Instruction-fetch front end that sits between a multi-cycle instruction memory and the IF/ID pipeline register.
- Issues sequential fetch requests and tracks in-flight responses.
- Buffers returned instructions with their PC in a small in-order queue.
- Presents the queue head to IF/ID as out_pc / out_pc_plus_4 / out_inst.
- On a taken branch or jump resolved in MEM (redirect), flushes the queue, discards stale responses and restarts fetch at redirect_pc.

---
 rtl/cpu_pkg.sv | 13 +
 rtl/fq_ring_buffer.sv | 81 ++++++++
 rtl/fetch_queue.sv | 110 +++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU front-end constants and small elaboration helpers.
package cpu_pkg;

    localparam int unsigned DEFAULT_DATA_WIDTH = 32;
    localparam logic [31:0] DEFAULT_RESET_PC   = 32'h0000_0000;
    localparam logic [31:0] NOP_INST           = 32'h0000_0013;

    // Bits needed to hold a count in 0..depth inclusive.
    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fq_ring_buffer.sv
// In-order ring buffer for fetched {pc, inst} entries with push, pop and clear.
module fq_ring_buffer
    import cpu_pkg::*;
#(
    parameter  int unsigned WIDTH = 64,
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned PW    = $clog2(DEPTH),
    localparam int unsigned CW    = cnt_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic [CW-1:0]    count,
    output logic             empty
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    head_q, head_d;
    logic [PW-1:0]    tail_q, tail_d;
    logic [CW-1:0]    count_q, count_d;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push & ~clear;
    assign do_pop  = pop & ~clear & ~empty;

    // Pointers wrap naturally since DEPTH is a power of two.
    always_comb begin
        mem_d   = mem_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (clear) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (do_push) begin
                mem_d[tail_q] = push_data;
                tail_d        = tail_q + PW'(1);
            end
            if (do_pop) begin
                head_d = head_q + PW'(1);
            end
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Payload storage needs no reset; validity is tracked by count_q.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign head_data = mem_q[head_q];
    assign count     = count_q;

    // The issue credit rule must keep a full buffer from ever receiving a push.
    a_no_overflow: assert property (@(posedge clk) disable iff (!rstn)
        !(push && !clear && full && !pop));

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch front end: credit-limited sequential issue, in-order response
// buffering and redirect handling with stale-response dropping.
module fetch_queue
    import cpu_pkg::*;
#(
    parameter int unsigned          DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int unsigned          DEPTH      = 4,
    parameter logic [DATA_WIDTH-1:0] RESET_PC  = DATA_WIDTH'(DEFAULT_RESET_PC)
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  redirect,
    input  logic [DATA_WIDTH-1:0] redirect_pc,
    input  logic                  pop,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_pc,
    output logic [DATA_WIDTH-1:0] out_pc_plus_4,
    output logic [DATA_WIDTH-1:0] out_inst,
    output logic                  imem_req,
    output logic [DATA_WIDTH-1:0] imem_addr,
    input  logic                  imem_ready,
    input  logic                  imem_rvalid,
    input  logic [DATA_WIDTH-1:0] imem_rdata
);

    localparam int unsigned CW = cnt_width(DEPTH);
    localparam int unsigned SW = CW + 1;
    localparam int unsigned EW = 2 * DATA_WIDTH;

    logic [DATA_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [DATA_WIDTH-1:0] resp_pc_q, resp_pc_d;
    logic [CW-1:0]         inflight_q, inflight_d;
    logic [CW-1:0]         drop_q, drop_d;
    logic [CW-1:0]         rb_count;
    logic                  rb_empty;
    logic [EW-1:0]         rb_head;
    logic [SW-1:0]         credits_used;
    logic                  xfer;
    logic                  rb_push;
    logic                  rb_pop;

    // Slots already claimed: buffered entries plus responses that will survive.
    assign credits_used = SW'(rb_count) + SW'(inflight_q) - SW'(drop_q);
    assign imem_req     = rstn & ~redirect & (inflight_q < CW'(DEPTH))
                        & (credits_used < SW'(DEPTH));
    assign imem_addr    = fetch_pc_q;
    assign xfer         = imem_req & imem_ready;
    assign rb_push      = imem_rvalid & ~redirect & (drop_q == '0);
    assign rb_pop       = pop & ~redirect;

    // Surviving responses are sequential from the last restart, so a counter
    // tracks the pc of the next response instead of a tag FIFO.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        drop_d     = drop_q;
        inflight_d = inflight_q + CW'(xfer) - CW'(imem_rvalid);
        if (redirect) begin
            fetch_pc_d = redirect_pc;
            resp_pc_d  = redirect_pc;
            drop_d     = inflight_q - CW'(imem_rvalid);
        end else begin
            if (xfer) begin
                fetch_pc_d = fetch_pc_q + DATA_WIDTH'(4);
            end
            if (imem_rvalid) begin
                if (drop_q != '0) begin
                    drop_d = drop_q - CW'(1);
                end else begin
                    resp_pc_d = resp_pc_q + DATA_WIDTH'(4);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            inflight_q <= '0;
            drop_q     <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
        end
    end

    fq_ring_buffer #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_rb (
        .clk       (clk),
        .rstn      (rstn),
        .clear     (redirect),
        .push      (rb_push),
        .push_data ({resp_pc_q, imem_rdata}),
        .pop       (rb_pop),
        .head_data (rb_head),
        .count     (rb_count),
        .empty     (rb_empty)
    );

    assign out_valid     = ~rb_empty;
    assign out_pc        = rb_head[EW-1:DATA_WIDTH];
    assign out_inst      = rb_head[DATA_WIDTH-1:0];
    assign out_pc_plus_4 = out_pc + DATA_WIDTH'(4);

endmodule
